// File: rtl/exec_seq_pkg.sv
// Shared definitions for the execution sequencer: state encoding, debug command codes,
// drain-counter width and an "enable is high in this state" helper.
// Latency: n/a (definitions only). Backpressure: n/a.
package exec_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_RUN   = 3'd1;
    localparam state_t S_STEP  = 3'd2;
    localparam state_t S_DRAIN = 3'd3;
    localparam state_t S_DONE  = 3'd4;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_STOP = 2'b11;

    // Wide enough for the largest legal drain length (31).
    localparam int DRAIN_W = 5;

    function automatic logic is_active(input state_t s);
        return (s == S_RUN) || (s == S_STEP) || (s == S_DRAIN);
    endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter that saturates at zero; `last` is high while the count is 1.
// Latency: load/decrement visible one edge later. Backpressure: none.
// Ports: clock, reset (async active-low), load/load_val, dec, last.
module down_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign last = (count == W'(1));

endmodule

// File: rtl/exec_sequencer.sv
// Clock-enable sequencer: runs RUN/STEP/STOP debug commands, drains the pipe after halt.
// Latency: command accepted at edge k -> o_enable from edge k+1; halt -> PIPE_DEPTH drain cycles.
// Backpressure: o_cmd_ready low in STEP and DRAIN; optional breakpoint via EXEC_SEQ_BREAKPOINT_EN.
//
// Ports: clock/reset (async active-low); command side i_cmd_valid/i_cmd/i_step_count/o_cmd_ready;
// pipeline side i_halt; status o_enable/o_busy/o_done/o_halted/o_cycle_count;
// with EXEC_SEQ_BREAKPOINT_EN also i_pc/i_bp_addr/i_bp_valid/o_bp_hit.
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int PIPE_DEPTH = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_cmd_valid,
    input  logic [1:0]       i_cmd,
    input  logic [NBITS-1:0] i_step_count,
    input  logic             i_halt,
    output logic             o_cmd_ready,
    output logic             o_enable,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_halted,
    output logic [NBITS-1:0] o_cycle_count
`ifdef EXEC_SEQ_BREAKPOINT_EN
    ,
    input  logic [NBITS-1:0] i_pc,
    input  logic [NBITS-1:0] i_bp_addr,
    input  logic             i_bp_valid,
    output logic             o_bp_hit
`endif
);

    state_t           state, state_nxt;
    logic             enable_q, done_q, halted_q;
    logic [NBITS-1:0] count_q;
    logic             accept;
    logic             step_load, drain_load, done_set, halted_set;
    logic             step_last, drain_last;
`ifdef EXEC_SEQ_BREAKPOINT_EN
    logic             bp_q, bp_set, bp_clr, bp_match;
    assign bp_match = i_bp_valid && (i_pc == i_bp_addr);
`endif

    assign o_cmd_ready = (state != S_STEP) && (state != S_DRAIN);
    assign accept      = i_cmd_valid && o_cmd_ready;

    always_comb begin
        state_nxt  = state;
        step_load  = 1'b0;
        drain_load = 1'b0;
        done_set   = 1'b0;
        halted_set = 1'b0;
`ifdef EXEC_SEQ_BREAKPOINT_EN
        bp_set     = 1'b0;
        bp_clr     = accept;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    case (i_cmd)
                        // After program end the core must not be clocked again until reset.
                        CMD_RUN: if (!halted_q) state_nxt = S_RUN;
                        CMD_STEP: begin
                            if (!halted_q) begin
                                if (i_step_count == '0) begin
                                    state_nxt = S_DONE;
                                    done_set  = 1'b1;
                                end else begin
                                    state_nxt = S_STEP;
                                    step_load = 1'b1;
                                end
                            end
                        end
                        CMD_STOP: state_nxt = S_IDLE;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // Halt beats everything: in-flight instructions must always drain.
                if (i_halt) begin
                    state_nxt  = S_DRAIN;
                    drain_load = 1'b1;
`ifdef EXEC_SEQ_BREAKPOINT_EN
                end else if (bp_match) begin
                    state_nxt = S_DONE;
                    done_set  = 1'b1;
                    bp_set    = 1'b1;
`endif
                end else if (accept && (i_cmd == CMD_STOP)) begin
                    state_nxt = S_IDLE;
                end
            end
            S_STEP: begin
                if (i_halt) begin
                    state_nxt  = S_DRAIN;
                    drain_load = 1'b1;
                end else if (step_last) begin
                    state_nxt = S_DONE;
                    done_set  = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_last) begin
                    state_nxt  = S_DONE;
                    done_set   = 1'b1;
                    halted_set = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state    <= state_nxt;
            // Registered copy of "next state is active" so the enable leaves a flop, glitch-free.
            enable_q <= is_active(state_nxt);
            done_q   <= done_set;
            halted_q <= halted_q | halted_set;
            if (enable_q) begin
                count_q <= count_q + NBITS'(1);
            end
        end
    end

`ifdef EXEC_SEQ_BREAKPOINT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bp_q <= 1'b0;
        end else if (bp_set) begin
            bp_q <= 1'b1;
        end else if (bp_clr) begin
            bp_q <= 1'b0;
        end
    end
    assign o_bp_hit = bp_q;
`endif

    down_counter #(.W(NBITS)) u_step_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (step_load),
        .load_val (i_step_count),
        .dec      (state == S_STEP),
        .last     (step_last)
    );

    down_counter #(.W(DRAIN_W)) u_drain_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (drain_load),
        .load_val (DRAIN_W'(PIPE_DEPTH)),
        .dec      (state == S_DRAIN),
        .last     (drain_last)
    );

    assign o_enable      = enable_q;
    assign o_busy        = enable_q;
    assign o_done        = done_q;
    assign o_halted      = halted_q;
    assign o_cycle_count = count_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: a per-cycle vector table plus hand-written
// sequences for STEP length, halt drain, STEP N=0, async reset and breakpoints.
// Latency: n/a. Backpressure: n/a.
module tb_exec_sequencer;

    localparam int NB = 32;
    localparam logic [1:0] C_NOP  = 2'b00;
    localparam logic [1:0] C_RUN  = 2'b01;
    localparam logic [1:0] C_STEP = 2'b10;
    localparam logic [1:0] C_STOP = 2'b11;

    logic          clock, reset;
    logic          vld, halt;
    logic [1:0]    cmd;
    logic [NB-1:0] n;
    logic          rdy, en, busy, done, halted;
    logic [NB-1:0] cnt;
`ifdef EXEC_SEQ_BREAKPOINT_EN
    logic [NB-1:0] pc, bp_addr;
    logic          bp_valid, bp_hit;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    exec_sequencer #(.NBITS(NB), .PIPE_DEPTH(5)) dut (
        .clock         (clock),
        .reset         (reset),
        .i_cmd_valid   (vld),
        .i_cmd         (cmd),
        .i_step_count  (n),
        .i_halt        (halt),
        .o_cmd_ready   (rdy),
        .o_enable      (en),
        .o_busy        (busy),
        .o_done        (done),
        .o_halted      (halted),
        .o_cycle_count (cnt)
`ifdef EXEC_SEQ_BREAKPOINT_EN
        ,
        .i_pc          (pc),
        .i_bp_addr     (bp_addr),
        .i_bp_valid    (bp_valid),
        .o_bp_hit      (bp_hit)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic          vld;
        logic [1:0]    cmd;
        logic [NB-1:0] n;
        logic          halt;
        logic          en;
        logic          rdy;
        logic          done;
        logic [NB-1:0] cnt;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic v, input logic [1:0] c, input logic [NB-1:0] nn,
                                input logic h, input logic e, input logic r, input logic d,
                                input logic [NB-1:0] k);
        vec_t t;
        t.vld = v; t.cmd = c; t.n = nn; t.halt = h;
        t.en = e; t.rdy = r; t.done = d; t.cnt = k;
        return t;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        vld = 1'b0; cmd = C_NOP; n = '0; halt = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        #12;
        chk1("rst_enable", en, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk1("rst_ready", rdy, 1'b1);
        chk32("rst_count", cnt, '0);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int en_cycles;
        int done_pulses;
        logic rdy_low_ok;
        reset = 1'b0;
        idle_inputs();
`ifdef EXEC_SEQ_BREAKPOINT_EN
        pc = '0; bp_addr = '0; bp_valid = 1'b0;
`endif

        //                  vld   cmd     n      halt  en    rdy   done  count
        vecs[0]  = mk(1'b1, C_RUN,  32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        vecs[1]  = mk(1'b0, C_NOP,  32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd1);
        vecs[2]  = mk(1'b1, C_RUN,  32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd2);
        vecs[3]  = mk(1'b1, C_STOP, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3);
        vecs[4]  = mk(1'b0, C_NOP,  32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3);
        vecs[5]  = mk(1'b1, C_STEP, 32'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3);
        vecs[6]  = mk(1'b0, C_NOP,  32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd4);
        vecs[7]  = mk(1'b0, C_NOP,  32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd5);
        vecs[8]  = mk(1'b0, C_NOP,  32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5);
        vecs[9]  = mk(1'b1, C_STEP, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd5);
        vecs[10] = mk(1'b0, C_NOP,  32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5);
        vecs[11] = mk(1'b1, C_STOP, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            vld = vecs[i].vld; cmd = vecs[i].cmd; n = vecs[i].n; halt = vecs[i].halt;
            tick();
            chk1($sformatf("vec%0d_enable", i), en, vecs[i].en);
            chk1($sformatf("vec%0d_busy", i), busy, vecs[i].en);
            chk1($sformatf("vec%0d_ready", i), rdy, vecs[i].rdy);
            chk1($sformatf("vec%0d_done", i), done, vecs[i].done);
            chk32($sformatf("vec%0d_count", i), cnt, vecs[i].cnt);
        end

        // RUN for 10 cycles, then STOP.
        do_reset();
        done_pulses = 0;
        vld = 1'b1; cmd = C_RUN;
        tick();
        idle_inputs();
        chk1("run_first_enable", en, 1'b1);
        for (int i = 1; i < 10; i++) begin
            tick();
            if (done) done_pulses++;
            chk1($sformatf("run_enable_c%0d", i), en, 1'b1);
        end
        vld = 1'b1; cmd = C_STOP;
        tick();
        idle_inputs();
        if (done) done_pulses++;
        chk1("stop_enable", en, 1'b0);
        chk32("stop_count", cnt, 32'd10);
        chk32("stop_no_done", done_pulses, 0);

        // STEP N=7.
        do_reset();
        en_cycles = 0; done_pulses = 0; rdy_low_ok = 1'b1;
        vld = 1'b1; cmd = C_STEP; n = 32'd7;
        tick();
        idle_inputs();
        for (int i = 0; i < 20; i++) begin
            if (en) begin
                en_cycles++;
                if (rdy) rdy_low_ok = 1'b0;
            end
            if (done) done_pulses++;
            tick();
        end
        chk32("step7_enable_cycles", en_cycles, 7);
        chk32("step7_done_pulses", done_pulses, 1);
        chk32("step7_count", cnt, 32'd7);
        chk1("step7_ready_low", rdy_low_ok, 1'b1);

        // RUN, halt at cycle 20 together with STOP (halt must win), drain 5.
        do_reset();
        vld = 1'b1; cmd = C_RUN;
        tick();
        idle_inputs();
        for (int i = 1; i < 20; i++) tick();
        halt = 1'b1; vld = 1'b1; cmd = C_STOP;
        tick();
        idle_inputs();
        en_cycles = 0; done_pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (en) en_cycles++;
            if (done) done_pulses++;
            tick();
        end
        chk32("drain_enable_cycles", en_cycles, 5);
        chk32("drain_done_pulses", done_pulses, 1);
        chk1("drain_halted", halted, 1'b1);
        chk32("drain_count", cnt, 32'd25);
        vld = 1'b1; cmd = C_RUN;
        tick();
        vld = 1'b1; cmd = C_STEP; n = 32'd3;
        tick();
        idle_inputs();
        tick();
        chk1("halted_run_ignored", en, 1'b0);
        chk32("halted_count_frozen", cnt, 32'd25);
        chk1("halted_sticky", halted, 1'b1);

        // Halt in STEP on the same cycle the counter reaches 1: halt wins.
        do_reset();
        vld = 1'b1; cmd = C_STEP; n = 32'd2;
        tick();
        idle_inputs();
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk1("step_halt_drain", en, 1'b1);
        en_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (en) en_cycles++;
            tick();
        end
        chk32("step_halt_enable_cycles", en_cycles, 5);
        chk1("step_halt_halted", halted, 1'b1);

        // STEP N=0 from IDLE.
        do_reset();
        vld = 1'b1; cmd = C_STEP; n = 32'd0;
        tick();
        idle_inputs();
        chk1("step0_done", done, 1'b1);
        chk1("step0_enable", en, 1'b0);
        tick();
        chk1("step0_done_clears", done, 1'b0);
        chk32("step0_count", cnt, 32'd0);

        // Asynchronous reset in the middle of STEP N=100.
        do_reset();
        vld = 1'b1; cmd = C_STEP; n = 32'd100;
        tick();
        idle_inputs();
        for (int i = 1; i < 40; i++) tick();
        chk1("midstep_enable_pre", en, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk1("midstep_rst_enable", en, 1'b0);
        chk1("midstep_rst_busy", busy, 1'b0);
        chk32("midstep_rst_count", cnt, 32'd0);
        chk1("midstep_rst_ready", rdy, 1'b1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        vld = 1'b1; cmd = C_RUN;
        tick();
        idle_inputs();
        chk1("midstep_run_after", en, 1'b1);

`ifdef EXEC_SEQ_BREAKPOINT_EN
        // Breakpoint at 0x10 while running.
        do_reset();
        bp_addr = 32'h10; bp_valid = 1'b1; pc = '0;
        vld = 1'b1; cmd = C_RUN;
        tick();
        idle_inputs();
        done_pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            pc = NB'(i);
            tick();
            if (!en) break;
        end
        chk32("bp_stop_pc", pc, 32'h10);
        chk1("bp_done", done, 1'b1);
        chk1("bp_hit", bp_hit, 1'b1);
        tick();
        chk1("bp_hit_holds", bp_hit, 1'b1);
        chk1("bp_enable_low", en, 1'b0);
        bp_valid = 1'b0;
        vld = 1'b1; cmd = C_NOP;
        tick();
        idle_inputs();
        chk1("bp_hit_clears", bp_hit, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
